mm_cmd_master: RTL
==================

// Module: mm_cmd_master
// PURPOSE
//  Byte-stream to Avalon-MM master bridge. Sits upstream of the LED blinker register block.
//  Parses command packets from an RX byte stream (UART RX side) and issues single 32-bit MM read/write transactions.
//  Returns status/read data as bytes on a TX stream. Can also pulse the slave's master_rst.
// PARAMETERS
//  RST_PULSE_CYCLES  4     cycles mm_rst_out is held high by the RESET command (>=1)
//  TIMEOUT_CYCLES    1024  max cycles spent waiting in WR_ISSUE/RD_ISSUE/RD_WAIT (only with MM_TIMEOUT_EN)
// PORTS
//  clk               in   1   clock
//  rst               in   1   asynchronous, active-low reset
//  rx_data           in   8   command byte
//  rx_valid          in   1   rx_data valid
//  rx_ready          out  1   byte accepted when rx_valid & rx_ready
//  tx_data           out  8   response byte
//  tx_valid          out  1   tx_data valid; held stable until tx_ready
//  tx_ready          in   1   downstream accepts byte
//  mm_address        out  32  MM byte address
//  mm_read           out  1   MM read strobe
//  mm_write          out  1   MM write strobe
//  mm_writedata      out  32  MM write data
//  mm_readdata       in   32  MM read data
//  mm_readdatavalid  in   1   MM read data valid
//  mm_waitrequest    in   1   MM stall; command accepted when strobe & ~mm_waitrequest
//  mm_rst_out        out  1   active-high reset pulse to slave (drives its master_rst)
//  busy              out  1   high in any state except IDLE
// BEHAVIOUR
//  Reset values
//   - All outputs 0.
//   - Internal address/data shift registers 0; state IDLE.
//   - Reset mid-transaction aborts it; no response is sent.
//  Packet format (multi-byte fields little-endian)
//   - 0x01 WRITE: opcode, addr[4], data[4].
//   - 0x02 READ: opcode, addr[4].
//   - 0x03 RESET: opcode only.
//  Responses
//   - WRITE: 0xA1.
//   - READ: 0xA2, then data[4].
//   - RESET: 0xA3.
//   - Unknown opcode: 0xEE; the byte is consumed and dropped.
//   - Timeout: 0xEF.
//  rx_ready=1 only in IDLE, ADDR, WDATA (one byte per cycle max).
//  FSM
//   - IDLE -> ADDR (op 1/2), RSTP (op 3), RESP (other).
//   - ADDR: 4 bytes -> WDATA (write) or RD_ISSUE (read).
//   - WDATA: 4 bytes -> WR_ISSUE.
//   - WR_ISSUE: mm_write=1 and address/data stable until ~mm_waitrequest -> RESP.
//   - RD_ISSUE: mm_read=1 until ~mm_waitrequest -> RD_WAIT.
//   - RD_WAIT: first mm_readdatavalid captures mm_readdata -> RESP.
//       - readdatavalid is sampled only from the cycle after acceptance.
//       - readdatavalid seen in the acceptance cycle is ignored (slave may hold it high).
//   - RSTP: mm_rst_out=1 for exactly RST_PULSE_CYCLES cycles -> RESP.
//   - RESP: emit 1 or 5 bytes, each advanced on tx_valid & tx_ready -> IDLE.
//  Strobes
//   - Registered outputs, asserted the cycle after entering the ISSUE state.
//   - Deasserted the cycle after acceptance; never read & write together.
//  Latency: last RX byte to mm_write high = 1 cycle; accepted RX bytes are never lost.
//  Byte counter is 2 bits and wraps 3->0; field complete on count==3 accept.
// CONFIGURATION
//  MM_TIMEOUT_EN defined
//   - 32-bit cycle counter cleared on entry to WR_ISSUE/RD_ISSUE, shared across RD_ISSUE+RD_WAIT.
//   - Reaching TIMEOUT_CYCLES drops the strobe, sends 0xEF, returns to IDLE.
//   - A late readdatavalid arriving in IDLE is ignored.
//  MM_TIMEOUT_EN undefined: waits forever; counter logic absent.
// STRUCTURE
//  Package mm_cmd_pkg
//   - opcode localparams OP_WRITE=8'h01, OP_READ=8'h02, OP_RESET=8'h03.
//   - response codes RSP_WR=8'hA1, RSP_RD=8'hA2, RSP_RST=8'hA3, RSP_BADOP=8'hEE, RSP_TMO=8'hEF.
//   - enum state_t {IDLE, ADDR, WDATA, WR_ISSUE, RD_ISSUE, RD_WAIT, RSTP, RESP}.
//  Sub-module mm_cmd_resp_ser
//   - loads 1 or 5 bytes; streams them over tx_valid/tx_ready; asserts done.
// TESTING
//  1. RX 01 00 00 00 00 01 00 00 00, waitrequest=0 -> one write, addr 0x0, wdata 0x1; TX 0xA1.
//  2. RX 02 04 00 00 00, waitrequest high 3 cycles, readdatavalid 2 cycles later with 0xDEADBEEF
//     -> mm_read held 4 cycles; TX A2 EF BE AD DE.
//  3. RX 03 -> mm_rst_out high exactly 4 cycles; TX 0xA3.
//  4. RX 0x55 -> TX 0xEE, no MM activity; next valid packet processed normally.
//  5. tx_ready low 10 cycles during read response -> tx_data/tx_valid stable; rx_ready=0; no byte lost.
//  6. MM_TIMEOUT_EN, TIMEOUT_CYCLES=16, waitrequest stuck 1 on read -> mm_read drops, TX 0xEF.
//     Also: reset asserted mid-WDATA -> all outputs 0, no TX.

Source files
------------

// File: rtl/mm_cmd_pkg.sv
// ---------------------------------------------------------------------------
// mm_cmd_pkg
// Shared definitions for the byte-stream to Avalon-MM command bridge:
// command opcodes, response codes and the controller state encoding.
// ---------------------------------------------------------------------------
package mm_cmd_pkg;

  // Command opcodes, the first byte of every packet
  localparam logic [7:0] OP_WRITE  = 8'h01;
  localparam logic [7:0] OP_READ   = 8'h02;
  localparam logic [7:0] OP_RESET  = 8'h03;

  // Response codes, the first byte of every response
  localparam logic [7:0] RSP_WR    = 8'hA1;
  localparam logic [7:0] RSP_RD    = 8'hA2;
  localparam logic [7:0] RSP_RST   = 8'hA3;
  localparam logic [7:0] RSP_BADOP = 8'hEE;
  localparam logic [7:0] RSP_TMO   = 8'hEF;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    ADDR     = 3'd1,
    WDATA    = 3'd2,
    WR_ISSUE = 3'd3,
    RD_ISSUE = 3'd4,
    RD_WAIT  = 3'd5,
    RSTP     = 3'd6,
    RESP     = 3'd7
  } state_t;

  // States in which the bridge is willing to take an RX byte
  function automatic logic is_rx_state(input state_t s);
    return (s == IDLE) || (s == ADDR) || (s == WDATA);
  endfunction

endpackage

// File: rtl/mm_cmd_resp_ser.sv
// ---------------------------------------------------------------------------
// mm_cmd_resp_ser
// Response serializer. Loads a 1- or 5-byte response in one cycle and
// streams it out lowest byte first over a valid/ready byte interface.
//
// Ports
//   clk, rst     clock, asynchronous active-low reset
//   load_i       capture bytes_i and start streaming
//   len5_i       1: response is 5 bytes long, 0: 1 byte
//   bytes_i      response bytes, byte 0 in [7:0]
//   tx_data_o    current byte, held while tx_valid_o & ~tx_ready_i
//   tx_valid_o   byte valid
//   tx_ready_i   downstream accepts byte
//   done_o       pulses in the cycle the final byte is accepted
// ---------------------------------------------------------------------------
module mm_cmd_resp_ser (
  input  logic        clk,
  input  logic        rst,
  input  logic        load_i,
  input  logic        len5_i,
  input  logic [39:0] bytes_i,
  output logic [7:0]  tx_data_o,
  output logic        tx_valid_o,
  input  logic        tx_ready_i,
  output logic        done_o
);

  logic [39:0] shift_q;
  logic [2:0]  remain_q;
  logic        valid_q;

  // Shift register drains one byte per handshake; remain_q counts what is
  // still to be sent including the byte currently presented.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shift_q  <= '0;
      remain_q <= '0;
      valid_q  <= 1'b0;
    end else if (load_i) begin
      shift_q  <= bytes_i;
      remain_q <= len5_i ? 3'd5 : 3'd1;
      valid_q  <= 1'b1;
    end else if (valid_q && tx_ready_i) begin
      shift_q  <= {8'h00, shift_q[39:8]};
      remain_q <= remain_q - 3'd1;
      if (remain_q == 3'd1) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign tx_data_o  = shift_q[7:0];
  assign tx_valid_o = valid_q;
  assign done_o     = valid_q && tx_ready_i && (remain_q == 3'd1);

endmodule

// File: rtl/mm_cmd_master.sv
// ---------------------------------------------------------------------------
// mm_cmd_master
// Byte-stream to Avalon-MM master bridge. Parses WRITE/READ/RESET command
// packets from an RX byte stream, issues single 32-bit MM transactions or a
// reset pulse to the slave, and returns a status byte (plus read data) on
// the TX byte stream.
//
// Optional feature: define MM_TIMEOUT_EN to bound the time spent waiting
// for the slave (TIMEOUT_CYCLES); without it the bridge waits forever.
//
// Ports
//   clk, rst          clock, asynchronous active-low reset
//   rx_data/valid     command byte in
//   rx_ready          byte accepted when rx_valid & rx_ready
//   tx_data/valid     response byte out, held until tx_ready
//   tx_ready          downstream accepts byte
//   mm_address        MM byte address
//   mm_read/mm_write  MM strobes, accepted when ~mm_waitrequest
//   mm_writedata      MM write data
//   mm_readdata       MM read data, qualified by mm_readdatavalid
//   mm_waitrequest    MM stall
//   mm_rst_out        active-high reset pulse to the slave
//   busy              high whenever the controller is not idle
// ---------------------------------------------------------------------------
module mm_cmd_master
  import mm_cmd_pkg::*;
#(
  parameter int RST_PULSE_CYCLES = 4,
  parameter int TIMEOUT_CYCLES   = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic [31:0] mm_address,
  output logic        mm_read,
  output logic        mm_write,
  output logic [31:0] mm_writedata,
  input  logic [31:0] mm_readdata,
  input  logic        mm_readdatavalid,
  input  logic        mm_waitrequest,
  output logic        mm_rst_out,
  output logic        busy
);

  state_t      state_q, state_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        is_wr_q, is_wr_d;
  logic [31:0] pulse_q, pulse_d;
  logic        rx_ready_q, mm_read_q, mm_write_q, mm_rst_q, busy_q;

  logic        rx_fire;
  logic        ser_load, ser_len5, ser_done;
  logic [39:0] ser_bytes;
  logic        tmo_hit;

  assign rx_fire = rx_valid && rx_ready_q;

`ifdef MM_TIMEOUT_EN
  logic [31:0] tmo_q, tmo_d;

  // One counter covers the whole slave wait: it restarts only when an issue
  // state is entered, so RD_ISSUE and RD_WAIT share a single budget.
  always_comb begin
    tmo_d = tmo_q + 32'd1;
    if ((state_d == WR_ISSUE && state_q != WR_ISSUE) ||
        (state_d == RD_ISSUE && state_q != RD_ISSUE)) begin
      tmo_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tmo_q <= '0;
    end else begin
      tmo_q <= tmo_d;
    end
  end

  assign tmo_hit = ((state_q == WR_ISSUE) || (state_q == RD_ISSUE) ||
                    (state_q == RD_WAIT)) &&
                   (tmo_q == 32'(TIMEOUT_CYCLES - 1));
`else
  logic unused_tmo_cfg;
  assign unused_tmo_cfg = (TIMEOUT_CYCLES > 0);
  assign tmo_hit        = 1'b0;
`endif

  // Next-state logic. Address and write data shift in little-endian, so
  // after four bytes the first received byte sits in bits [7:0]. The
  // response is loaded into the serializer on the transition into RESP.
  // A slave acceptance always wins over a simultaneous timeout.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    is_wr_d   = is_wr_q;
    pulse_d   = pulse_q;
    ser_load  = 1'b0;
    ser_len5  = 1'b0;
    ser_bytes = '0;
    case (state_q)
      IDLE: begin
        if (rx_fire) begin
          cnt_d = 2'd0;
          if (rx_data == OP_WRITE || rx_data == OP_READ) begin
            state_d = ADDR;
            is_wr_d = (rx_data == OP_WRITE);
          end else if (rx_data == OP_RESET) begin
            state_d = RSTP;
            pulse_d = '0;
          end else begin
            state_d   = RESP;
            ser_load  = 1'b1;
            ser_bytes = {32'h0, RSP_BADOP};
          end
        end
      end
      ADDR: begin
        if (rx_fire) begin
          addr_d = {rx_data, addr_q[31:8]};
          cnt_d  = cnt_q + 2'd1;
          if (cnt_q == 2'd3) begin
            state_d = is_wr_q ? WDATA : RD_ISSUE;
          end
        end
      end
      WDATA: begin
        if (rx_fire) begin
          wdata_d = {rx_data, wdata_q[31:8]};
          cnt_d   = cnt_q + 2'd1;
          if (cnt_q == 2'd3) begin
            state_d = WR_ISSUE;
          end
        end
      end
      WR_ISSUE: begin
        if (!mm_waitrequest) begin
          state_d   = RESP;
          ser_load  = 1'b1;
          ser_bytes = {32'h0, RSP_WR};
        end else if (tmo_hit) begin
          state_d   = RESP;
          ser_load  = 1'b1;
          ser_bytes = {32'h0, RSP_TMO};
        end
      end
      RD_ISSUE: begin
        if (!mm_waitrequest) begin
          state_d = RD_WAIT;
        end else if (tmo_hit) begin
          state_d   = RESP;
          ser_load  = 1'b1;
          ser_bytes = {32'h0, RSP_TMO};
        end
      end
      RD_WAIT: begin
        if (mm_readdatavalid) begin
          state_d   = RESP;
          ser_load  = 1'b1;
          ser_len5  = 1'b1;
          ser_bytes = {mm_readdata, RSP_RD};
        end else if (tmo_hit) begin
          state_d   = RESP;
          ser_load  = 1'b1;
          ser_bytes = {32'h0, RSP_TMO};
        end
      end
      RSTP: begin
        if (pulse_q == 32'(RST_PULSE_CYCLES - 1)) begin
          state_d   = RESP;
          ser_load  = 1'b1;
          ser_bytes = {32'h0, RSP_RST};
        end else begin
          pulse_d = pulse_q + 32'd1;
        end
      end
      RESP: begin
        if (ser_done) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and registered outputs. Every output flop is driven from the
  // next state, so strobes rise in the first cycle of their state and fall
  // in the first cycle after it, and everything reads 0 while in reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      is_wr_q    <= 1'b0;
      pulse_q    <= '0;
      rx_ready_q <= 1'b0;
      mm_read_q  <= 1'b0;
      mm_write_q <= 1'b0;
      mm_rst_q   <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      is_wr_q    <= is_wr_d;
      pulse_q    <= pulse_d;
      rx_ready_q <= is_rx_state(state_d);
      mm_read_q  <= (state_d == RD_ISSUE);
      mm_write_q <= (state_d == WR_ISSUE);
      mm_rst_q   <= (state_d == RSTP);
      busy_q     <= (state_d != IDLE);
    end
  end

  mm_cmd_resp_ser u_ser (
    .clk        (clk),
    .rst        (rst),
    .load_i     (ser_load),
    .len5_i     (ser_len5),
    .bytes_i    (ser_bytes),
    .tx_data_o  (tx_data),
    .tx_valid_o (tx_valid),
    .tx_ready_i (tx_ready),
    .done_o     (ser_done)
  );

  assign rx_ready     = rx_ready_q;
  assign mm_read      = mm_read_q;
  assign mm_write     = mm_write_q;
  assign mm_rst_out   = mm_rst_q;
  assign mm_address   = addr_q;
  assign mm_writedata = wdata_q;
  assign busy         = busy_q;

endmodule
